// File: rtl/prio_chan_arbiter.sv
// rtl/prio_chan_arbiter.sv - registered multi-bus priority channel arbiter with valid/ack handshake
module prio_chan_arbiter #(
    parameter int NUM_BUS = 3,
    parameter int CHAN    = 9,
    parameter int STICKY  = 1,
    parameter int RR      = 0,
    localparam int CW     = $clog2(CHAN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_BUS*CHAN-1:0] req,
    input  logic [CHAN-1:0]         en,
    output logic                    out_valid,
    input  logic                    out_ack,
    output logic [NUM_BUS-1:0]      bus_grant,
    output logic [CW-1:0]           chan_out,
    output logic                    any_pend
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                    state_q, state_d;
    logic [NUM_BUS*CHAN-1:0]   pend_q, pend_d;
    logic [NUM_BUS*CHAN-1:0]   elig;
    logic [NUM_BUS*CHAN-1:0]   clr;
    logic [CW-1:0]             rr_q [NUM_BUS];
    logic [CW-1:0]             rr_d [NUM_BUS];
    logic                      valid_q, valid_d;
    logic [NUM_BUS-1:0]        grant_q, grant_d;
    logic [CW-1:0]             chan_q, chan_d;
    logic                      any_pend_q;

    logic [CW-1:0]             cidx [NUM_BUS];
    logic [NUM_BUS-1:0]        win_grant;
    logic [CW-1:0]             win_chan;

    assign elig = pend_q & {NUM_BUS{en}};

    // Per-bus channel pick: search starts at rr pointer (RR) or 0, wrapping.
    always_comb begin
        int   start;
        int   idx;
        logic found;
        for (int b = 0; b < NUM_BUS; b++) begin
            start   = (RR != 0) ? int'(rr_q[b]) : 0;
            found   = 1'b0;
            cidx[b] = '0;
            for (int i = 0; i < CHAN; i++) begin
                idx = start + i;
                if (idx >= CHAN) idx = idx - CHAN;
                if (!found && elig[b*CHAN + idx]) begin
                    found   = 1'b1;
                    cidx[b] = CW'(idx);
                end
            end
        end
    end

    // Lowest-numbered bus with any eligible bit wins.
    always_comb begin
        win_grant = '0;
        win_chan  = '0;
        for (int b = NUM_BUS - 1; b >= 0; b--) begin
            if (|elig[b*CHAN +: CHAN]) begin
                win_grant    = '0;
                win_grant[b] = 1'b1;
                win_chan     = cidx[b];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        grant_d = grant_q;
        chan_d  = chan_q;
        clr     = '0;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = GRANT;
                    valid_d = 1'b1;
                    grant_d = win_grant;
                    chan_d  = win_chan;
                end
            end
            GRANT: begin
                if (out_ack) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    grant_d = '0;
                    chan_d  = '0;
                    for (int b = 0; b < NUM_BUS; b++) begin
                        if (grant_q[b]) begin
                            clr[b*CHAN +: CHAN] = CHAN'(1) << chan_q;
                            if (RR != 0)
                                rr_d[b] = (chan_q == CW'(CHAN - 1)) ? '0 : chan_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A request arriving in the ack cycle outranks the clear.
    assign pend_d = (STICKY != 0) ? ((pend_q & ~clr) | req) : req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            valid_q    <= 1'b0;
            grant_q    <= '0;
            chan_q     <= '0;
            any_pend_q <= 1'b0;
            for (int b = 0; b < NUM_BUS; b++) rr_q[b] <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            grant_q    <= grant_d;
            chan_q     <= chan_d;
            any_pend_q <= |elig;
            for (int b = 0; b < NUM_BUS; b++) rr_q[b] <= rr_d[b];
        end
    end

    assign out_valid = valid_q;
    assign bus_grant = grant_q;
    assign chan_out  = chan_q;
    assign any_pend  = any_pend_q;

endmodule

// File: tb/tb_prio_chan_arbiter.sv
// tb/tb_prio_chan_arbiter.sv - scoreboard bench for prio_chan_arbiter
module tb_prio_chan_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [26:0] req;
    logic [8:0]  en;
    logic        ack0, ack1, ack2;
    logic        v0, v1, v2;
    logic [2:0]  g0, g1, g2;
    logic [3:0]  c0, c1, c2;
    logic        p0, p1, p2;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] g;
        logic [3:0] c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    prio_chan_arbiter u0 (
        .clk(clk), .rst(rst), .req(req), .en(en), .out_valid(v0), .out_ack(ack0),
        .bus_grant(g0), .chan_out(c0), .any_pend(p0)
    );
    prio_chan_arbiter #(.STICKY(0), .RR(1)) u1 (
        .clk(clk), .rst(rst), .req(req), .en(en), .out_valid(v1), .out_ack(ack1),
        .bus_grant(g1), .chan_out(c1), .any_pend(p1)
    );
    prio_chan_arbiter #(.STICKY(0), .RR(0)) u2 (
        .clk(clk), .rst(rst), .req(req), .en(en), .out_valid(v2), .out_ack(ack2),
        .bus_grant(g2), .chan_out(c2), .any_pend(p2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for u0 grant, compare against scoreboard head, then ack.
    task automatic serve0(input string tag);
        exp_t e;
        for (int i = 0; i < 12 && v0 !== 1'b1; i++) tick();
        chk({tag, "_valid"}, v0, 1);
        chk({tag, "_sb"}, q0.size() != 0, 1);
        if (v0 === 1'b1 && q0.size() != 0) begin
            e = q0.pop_front();
            chk({tag, "_grant"}, g0, e.g);
            chk({tag, "_chan"}, c0, e.c);
        end
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        chk({tag, "_drop"}, v0, 0);
        chk({tag, "_gzero"}, g0, 0);
    endtask

    initial begin
        exp_t e;
        rst  = 1'b1;
        req  = '1;
        en   = 9'h1FF;
        ack0 = 1'b0;
        ack1 = 1'b0;
        ack2 = 1'b0;

        // Reset with all requests asserted
        tick();
        tick();
        chk("rst_valid", v0, 0);
        chk("rst_grant", g0, 0);
        chk("rst_chan", c0, 0);
        chk("rst_pend", p0, 0);
        rst = 1'b0;
        req = '0;
        tick();

        // Bus priority: A ch1 before B ch0
        req = {9'h000, 9'h001, 9'h002};
        q0.push_back('{g: 3'b001, c: 4'd1});
        q0.push_back('{g: 3'b010, c: 4'd0});
        tick();
        req = '0;
        tick();
        chk("t2_latency", v0, 1);
        serve0("t2_a");
        tick();
        chk("t2_idle_gap", v0, 1);
        serve0("t2_b");
        tick();
        tick();
        chk("t2_anypend", p0, 0);
        chk("t2_novalid", v0, 0);

        // Disabled channel stays pending, granted once enabled
        en  = 9'h000;
        req = {9'h000, 9'h000, 9'h010};
        tick();
        req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_masked_valid", v0, 0);
            chk("t3_masked_pend", p0, 0);
        end
        en = 9'h1FF;
        q0.push_back('{g: 3'b001, c: 4'd4});
        serve0("t3");

        // Re-request in ack cycle survives the clear
        req = {9'h000, 9'h000, 9'h008};
        q0.push_back('{g: 3'b001, c: 4'd3});
        tick();
        req = '0;
        tick();
        chk("t5_first_valid", v0, 1);
        e = q0.pop_front();
        chk("t5_first_chan", c0, e.c);
        chk("t5_first_grant", g0, e.g);
        ack0 = 1'b1;
        req  = {9'h000, 9'h000, 9'h008};
        tick();
        ack0 = 1'b0;
        req  = '0;
        chk("t5_gap", v0, 0);
        q0.push_back('{g: 3'b001, c: 4'd3});
        tick();
        chk("t5_regrant", v0, 1);
        serve0("t5");

        // Level-sampled: round-robin vs fixed priority, A=005 held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = {9'h000, 9'h000, 9'h005};
        q1.push_back('{g: 3'b001, c: 4'd0});
        q1.push_back('{g: 3'b001, c: 4'd2});
        q1.push_back('{g: 3'b001, c: 4'd0});
        q1.push_back('{g: 3'b001, c: 4'd2});
        for (int n = 0; n < 4; n++) q2.push_back('{g: 3'b001, c: 4'd0});
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 12 && !(v1 === 1'b1 && v2 === 1'b1); i++) tick();
            chk("t4_rr_valid", v1, 1);
            chk("t4_fp_valid", v2, 1);
            e = q1.pop_front();
            chk("t4_rr_chan", c1, e.c);
            chk("t4_rr_grant", g1, e.g);
            e = q2.pop_front();
            chk("t4_fp_chan", c2, e.c);
            ack1 = 1'b1;
            ack2 = 1'b1;
            tick();
            ack1 = 1'b0;
            ack2 = 1'b0;
        end
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Reset during GRANT drops the grant and pending state
        req = {9'h000, 9'h000, 9'h020};
        tick();
        req = '0;
        tick();
        chk("t6_valid", v0, 1);
        chk("t6_chan", c0, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_valid", v0, 0);
        chk("t6_rst_grant", g0, 0);
        chk("t6_rst_chan", c0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_regrant", v0, 0);
            chk("t6_no_pend", p0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
